// File: rtl/hi_lo_controller.sv
// HI/LO register controller: one-cycle-latency multiply/accumulate, 32-step
// restoring divide, and MTHI/MTLO moves, with a pipeline stall for MFHI/MFLO.
module hi_lo_controller (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        MfRead,
    output logic [31:0] ReadDataHi,
    output logic [31:0] ReadDataLo,
    output logic        Busy,
    output logic        Stall,
    output logic        Done
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

    state_t      state, stateNext;
    logic        accept;
    logic [31:0] hi, lo;
    logic [2:0]  opLat;
    logic [31:0] opA, opB;
    logic [31:0] rem, quo;
    logic [5:0]  cnt;
    logic        signQ, signR, divZero, done;

    // Next-state decode; Op is only looked at on the accept cycle.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept = 1'b1;
                    case (Op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: stateNext = MUL;
                        OP_DIV, OP_DIVU:                     stateNext = DIV_ITER;
                        default:                             stateNext = IDLE;
                    endcase
                end
            end
            MUL:      stateNext = IDLE;
            DIV_ITER: if (cnt == 6'd31) stateNext = DIV_FIX;
            DIV_FIX:  stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Multiply: a single 64x64 low-half product covers signed and unsigned.
    logic        mulSigned;
    logic [63:0] mA, mB, prod, mulRes;
    assign mulSigned = (opLat != OP_MULTU);
    assign mA   = mulSigned ? {{32{opA[31]}}, opA} : {32'd0, opA};
    assign mB   = mulSigned ? {{32{opB[31]}}, opB} : {32'd0, opB};
    assign prod = mA * mB;

    always_comb begin
        case (opLat)
            OP_MADD: mulRes = {hi, lo} + prod;
            OP_MSUB: mulRes = {hi, lo} - prod;
            default: mulRes = prod;
        endcase
    end

    // Divide operands are held as magnitudes; signs are reapplied at DIV_FIX.
    logic        divSigned, aNeg, bNeg;
    logic [31:0] aMag, bMag;
    assign divSigned = (Op == OP_DIV);
    assign aNeg      = divSigned & OperandA[31];
    assign bNeg      = divSigned & OperandB[31];
    assign aMag      = aNeg ? 32'd0 - OperandA : OperandA;
    assign bMag      = bNeg ? 32'd0 - OperandB : OperandB;

    // Remainder stays below the divisor, so the 32-bit difference is exact.
    logic [32:0] remSh;
    logic        fits;
    logic [31:0] diff, quoFix, remFix;
    assign remSh  = {rem, quo[31]};
    assign fits   = (remSh >= {1'b0, opB});
    assign diff   = remSh[31:0] - opB;
    assign quoFix = signQ ? 32'd0 - quo : quo;
    assign remFix = signR ? 32'd0 - rem : rem;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            opLat   <= '0;
            opA     <= '0;
            opB     <= '0;
            rem     <= '0;
            quo     <= '0;
            signQ   <= 1'b0;
            signR   <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opLat <= Op;
                        opA   <= OperandA;
                        opB   <= OperandB;
                        cnt   <= '0;
                        if (Op == OP_MTHI) hi <= OperandA;
                        if (Op == OP_MTLO) lo <= OperandA;
                        if (Op == OP_DIV || Op == OP_DIVU) begin
                            opB     <= bMag;
                            quo     <= aMag;
                            rem     <= '0;
                            signQ   <= aNeg ^ bNeg;
                            signR   <= aNeg;
                            divZero <= (OperandB == 32'd0);
                        end
                    end
                end
                MUL: begin
                    {hi, lo} <= mulRes;
                    done     <= 1'b1;
                end
                DIV_ITER: begin
                    cnt <= cnt + 6'd1;
                    quo <= {quo[30:0], fits};
                    rem <= fits ? diff : remSh[31:0];
                end
                DIV_FIX: begin
                    lo   <= divZero ? 32'hFFFF_FFFF : quoFix;
                    hi   <= remFix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ReadDataHi = hi;
    assign ReadDataLo = lo;
    assign Busy       = (state != IDLE);
    assign Stall      = MfRead & Busy;
    assign Done       = done;
endmodule
